// File: rtl/phy_tx_striper_if.sv
// Handshake and data bundle for the PCIe TX lane striper.
// master drives words in and observes lanes; slave is the striper itself.
interface phy_tx_striper_if #(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned SYM_W  = 8,
   parameter int unsigned LANES  = 2
);
   logic [WORD_W-1:0]       data_input;
   logic                    valid;
   logic                    active;
   logic                    ready;
   logic [LANES*SYM_W-1:0]  data_out;
   logic [LANES-1:0]        valid_out;
   logic [WORD_W-1:0]       recirc_data;
   logic                    recirc_valid;

   modport master (
      output data_input, valid, active,
      input  ready, data_out, valid_out, recirc_data, recirc_valid
   );

   modport slave (
      input  data_input, valid, active,
      output ready, data_out, valid_out, recirc_data, recirc_valid
   );
endinterface

// File: rtl/phy_tx_striper.sv
// Parametrised TX striper: words are dealt round-robin to LANES holding registers,
// each lane serialises its word MS symbol first. With the link inactive, words go
// to the recirculation port instead.
module phy_tx_striper #(
   parameter int unsigned      WORD_W   = 32,
   parameter int unsigned      SYM_W    = 8,
   parameter int unsigned      LANES    = 2,
   parameter logic [SYM_W-1:0] IDLE_SYM = 8'hBC
) (
   input logic               clk_4f,
   input logic               reset,
   phy_tx_striper_if.slave   bus
);

   localparam int unsigned RATIO = WORD_W / SYM_W;
   localparam int unsigned CNT_W = $clog2(RATIO);
   localparam int unsigned PTR_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LANES - 1);

   typedef enum logic [0:0] {StIdle, StSend} lane_state_e;

   logic [PTR_W-1:0] lane_ptr_q, lane_ptr_d;
   logic [LANES-1:0] hold_full;
   logic             accept;
   logic [WORD_W-1:0] recirc_data_q;
   logic              recirc_valid_q;

   // No bypass: a full holding register blocks the lane even if it drains this edge.
   assign bus.ready = ~hold_full[lane_ptr_q];
   assign accept    = bus.valid & bus.active & bus.ready;

   // Round-robin pointer advances only on a striping accept.
   always_comb begin
      lane_ptr_d = lane_ptr_q;
      if (accept) begin
         lane_ptr_d = (lane_ptr_q == PTR_LAST) ? '0 : lane_ptr_q + 1'b1;
      end
   end

   // Lane pointer state.
   always_ff @(posedge clk_4f or negedge reset) begin
      if (!reset) begin
         lane_ptr_q <= '0;
      end else begin
         lane_ptr_q <= lane_ptr_d;
      end
   end

   // Recirculation path: independent of ready and of the lanes.
   always_ff @(posedge clk_4f or negedge reset) begin
      if (!reset) begin
         recirc_data_q  <= '0;
         recirc_valid_q <= 1'b0;
      end else if (bus.valid && !bus.active) begin
         recirc_data_q  <= bus.data_input;
         recirc_valid_q <= 1'b1;
      end else begin
         recirc_valid_q <= 1'b0;
      end
   end

   assign bus.recirc_data  = recirc_data_q;
   assign bus.recirc_valid = recirc_valid_q;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic              hold_full_q;
      logic [WORD_W-1:0] hold_q;
      logic [WORD_W-1:0] sr_q, sr_d;
      logic [SYM_W-1:0]  sym_q, sym_d;
      logic              vld_q, vld_d;
      logic [CNT_W-1:0]  cnt_q, cnt_d;
      lane_state_e       state_q, state_d;
      logic              load;
      logic              take;

      assign take = accept & (lane_ptr_q == PTR_W'(i));

      // Holding register; take and load never coincide because ready needs it empty.
      always_ff @(posedge clk_4f or negedge reset) begin
         if (!reset) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
         end else if (take) begin
            hold_q      <= bus.data_input;
            hold_full_q <= 1'b1;
         end else if (load) begin
            hold_full_q <= 1'b0;
         end
      end

      // Serialiser next state: sr holds the symbols still to be emitted, MS first.
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         sr_d    = sr_q;
         sym_d   = sym_q;
         vld_d   = vld_q;
         load    = 1'b0;
         unique case (state_q)
            StIdle: begin
               if (hold_full_q) begin
                  load = 1'b1;
               end else begin
                  sym_d = IDLE_SYM;
                  vld_d = 1'b0;
               end
            end
            StSend: begin
               if (cnt_q == CNT_LAST) begin
                  if (hold_full_q) begin
                     load = 1'b1;
                  end else begin
                     state_d = StIdle;
                     sym_d   = IDLE_SYM;
                     vld_d   = 1'b0;
                  end
               end else begin
                  sym_d = sr_q[WORD_W-1 -: SYM_W];
                  sr_d  = sr_q << SYM_W;
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
         // Back-to-back load emits symbol 0 of the next word with no gap.
         if (load) begin
            sym_d   = hold_q[WORD_W-1 -: SYM_W];
            sr_d    = hold_q << SYM_W;
            vld_d   = 1'b1;
            cnt_d   = '0;
            state_d = StSend;
         end
      end

      // Serialiser state and registered lane outputs.
      always_ff @(posedge clk_4f or negedge reset) begin
         if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sr_q    <= '0;
            sym_q   <= IDLE_SYM;
            vld_q   <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            sym_q   <= sym_d;
            vld_q   <= vld_d;
         end
      end

      assign hold_full[i]                    = hold_full_q;
      assign bus.data_out[i*SYM_W +: SYM_W]  = sym_q;
      assign bus.valid_out[i]                = vld_q;
   end

endmodule

// File: tb/tb_phy_tx_striper.sv
// Scoreboard bench for phy_tx_striper: a two-lane byte instance for the main
// behaviour and a four-lane 16-bit-symbol instance for the parameter sweep.
module tb_phy_tx_striper;

   logic clk_4f = 1'b0;
   logic reset;
   always #5 clk_4f = ~clk_4f;

   phy_tx_striper_if #(.WORD_W(32), .SYM_W(8), .LANES(2)) bus ();
   phy_tx_striper_if #(.WORD_W(32), .SYM_W(16), .LANES(4)) bus4 ();

   phy_tx_striper #(
      .WORD_W   (32),
      .SYM_W    (8),
      .LANES    (2),
      .IDLE_SYM (8'hBC)
   ) u_dut (
      .clk_4f (clk_4f),
      .reset  (reset),
      .bus    (bus)
   );

   phy_tx_striper #(
      .WORD_W   (32),
      .SYM_W    (16),
      .LANES    (4),
      .IDLE_SYM (16'hBCBC)
   ) u_dut4 (
      .clk_4f (clk_4f),
      .reset  (reset),
      .bus    (bus4)
   );

   int checks   = 0;
   int failures = 0;

   logic [7:0]  exp_q0[$];
   logic [7:0]  exp_q1[$];
   logic [31:0] exp_rc[$];
   int          model_ptr = 0;
   int          run0 = 0;
   int          max_run0 = 0;
   int          cyc = 0;
   logic        rec4 = 1'b0;
   int          log_cyc[$];
   int          log_lane[$];
   logic [15:0] log_sym[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected symbols of an accepted word go to the lane the model pointer selects.
   task automatic push_word(input logic [31:0] w);
      for (int k = 0; k < 4; k++) begin
         if (model_ptr == 0) exp_q0.push_back(w[31-8*k -: 8]);
         else                exp_q1.push_back(w[31-8*k -: 8]);
      end
      model_ptr = (model_ptr + 1) % 2;
   endtask

   task automatic mon_lane(input int l, input logic v, input logic [7:0] sym);
      logic [7:0] e;
      if (v) begin
         if ((l == 0 && exp_q0.size() == 0) || (l == 1 && exp_q1.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL lane%0d unexpected symbol: got %0h expected none", l, sym);
         end else begin
            e = (l == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("lane%0d symbol", l), {56'd0, sym}, {56'd0, e});
         end
      end else begin
         check($sformatf("lane%0d idle symbol", l), {56'd0, sym}, 64'hBC);
      end
   endtask

   always @(posedge clk_4f) cyc <= cyc + 1;

   // Monitor for the two-lane instance: pops the scoreboard whenever a qualifier is up.
   always @(negedge clk_4f) begin
      if (reset === 1'b1) begin
         mon_lane(0, bus.valid_out[0], bus.data_out[7:0]);
         mon_lane(1, bus.valid_out[1], bus.data_out[15:8]);
         if (bus.valid_out[0]) begin
            run0++;
            if (run0 > max_run0) max_run0 = run0;
         end else begin
            run0 = 0;
         end
         if (bus.recirc_valid) begin
            if (exp_rc.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL recirc unexpected: got %0h expected none", bus.recirc_data);
            end else begin
               check("recirc_data", {32'd0, bus.recirc_data}, {32'd0, exp_rc.pop_front()});
            end
         end
      end
   end

   // Recorder for the four-lane instance during the sweep.
   always @(negedge clk_4f) begin
      if (reset === 1'b1 && rec4) begin
         for (int l = 0; l < 4; l++) begin
            if (bus4.valid_out[l]) begin
               log_cyc.push_back(cyc);
               log_lane.push_back(l);
               log_sym.push_back(bus4.data_out[l*16 +: 16]);
            end
         end
      end
   end

   // Drives one word; starts and ends just after a rising edge, leaves valid high.
   task automatic send_word(input logic [31:0] w, input logic act);
      int waited;
      bus.data_input = w;
      bus.valid      = 1'b1;
      bus.active     = act;
      if (!act) begin
         @(negedge clk_4f);
         exp_rc.push_back(w);
         @(posedge clk_4f);
         #1;
         return;
      end
      waited = 0;
      forever begin
         @(negedge clk_4f);
         if (bus.ready) break;
         waited++;
         if (waited >= 50) begin
            checks++;
            failures++;
            $display("FAIL ready timeout: got 0 expected 1 within 50 cycles");
            @(posedge clk_4f);
            #1;
            return;
         end
      end
      push_word(w);
      @(posedge clk_4f);
      #1;
   endtask

   task automatic wait_drain();
      for (int c = 0; c < 400; c++) begin
         if (exp_q0.size() == 0 && exp_q1.size() == 0 && exp_rc.size() == 0) break;
         @(posedge clk_4f);
      end
      repeat (3) @(posedge clk_4f);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w;
      logic [31:0] w4[5];
      logic [15:0] exp4[4][4];
      int          cnt4[4];
      int          acc0;
      int          n;
      bit          seen_first;

      reset = 1'b1;
      bus.data_input = '0;  bus.valid = 1'b0;  bus.active = 1'b1;
      bus4.data_input = '0; bus4.valid = 1'b0; bus4.active = 1'b1;
      #1 reset = 1'b0;
      #1;
      check("reset data_out", {48'd0, bus.data_out}, 64'hBCBC);
      check("reset valid_out", {62'd0, bus.valid_out}, 64'd0);
      check("reset ready", {63'd0, bus.ready}, 64'd1);
      check("reset recirc_valid", {63'd0, bus.recirc_valid}, 64'd0);
      check("reset dut4 data_out", bus4.data_out, 64'hBCBCBCBCBCBCBCBC);
      repeat (2) @(posedge clk_4f);
      @(negedge clk_4f);
      reset = 1'b1;
      @(posedge clk_4f);
      #1;

      // Single word: symbols DE AD BE EF on lane 0 on edges 1..4 after accept.
      w = 32'hDEADBEEF;
      send_word(w, 1'b1);
      bus.valid = 1'b0;
      @(negedge clk_4f);
      check("single latency", {62'd0, bus.valid_out}, 64'd0);
      for (int s = 0; s < 4; s++) begin
         @(negedge clk_4f);
         check($sformatf("single valid_out s%0d", s), {62'd0, bus.valid_out}, 64'd1);
         check($sformatf("single lane0 s%0d", s), {56'd0, bus.data_out[7:0]},
               {56'd0, w[31-8*s -: 8]});
         check($sformatf("single lane1 s%0d", s), {56'd0, bus.data_out[15:8]}, 64'hBC);
      end
      @(negedge clk_4f);
      check("single end", {62'd0, bus.valid_out}, 64'd0);
      @(posedge clk_4f);
      #1;

      // Recirculation: one-edge latency, lanes untouched, data held afterwards.
      send_word(32'h12345678, 1'b0);
      bus.valid  = 1'b0;
      bus.active = 1'b1;
      @(negedge clk_4f);
      check("recirc valid", {63'd0, bus.recirc_valid}, 64'd1);
      check("recirc lanes quiet", {62'd0, bus.valid_out}, 64'd0);
      @(negedge clk_4f);
      check("recirc pulse", {63'd0, bus.recirc_valid}, 64'd0);
      check("recirc hold", {32'd0, bus.recirc_data}, 64'h12345678);
      @(posedge clk_4f);
      #1;

      // Pointer must still be 1 after recirculation: this word belongs on lane 1.
      send_word(32'h0BADF00D, 1'b1);
      bus.valid = 1'b0;
      wait_drain();

      // Streaming: even words on lane 0, odd on lane 1, lane 0 busy 16 cycles straight.
      max_run0 = 0;
      for (int i = 0; i < 8; i++) begin
         w = {4{8'(i)}};
         send_word(w, 1'b1);
      end
      bus.valid = 1'b0;
      wait_drain();
      check("stream lane0 run", max_run0, 16);

      // Reset mid-stream: immediate idle outputs, held words discarded.
      for (int i = 0; i < 3; i++) send_word(32'hA0A1A2A3 + i, 1'b1);
      #2 reset = 1'b0;
      #1;
      bus.valid = 1'b0;
      check("midrst data_out", {48'd0, bus.data_out}, 64'hBCBC);
      check("midrst valid_out", {62'd0, bus.valid_out}, 64'd0);
      check("midrst ready", {63'd0, bus.ready}, 64'd1);
      check("midrst recirc_valid", {63'd0, bus.recirc_valid}, 64'd0);
      check("midrst recirc_data", {32'd0, bus.recirc_data}, 64'd0);
      exp_q0.delete();
      exp_q1.delete();
      exp_rc.delete();
      model_ptr = 0;
      run0 = 0;
      @(negedge clk_4f);
      #1 reset = 1'b1;
      @(posedge clk_4f);
      #1;
      send_word(32'hCAFEF00D, 1'b1);
      bus.valid = 1'b0;
      wait_drain();

      // Random stalls and recirculation mixed in; scoreboard checks order and count.
      for (int i = 0; i < 1000; i++) begin
         int gap;
         gap = $urandom_range(0, 2);
         if (gap != 0) begin
            bus.valid = 1'b0;
            repeat (gap) begin
               @(posedge clk_4f);
               #1;
            end
         end
         send_word($urandom, ($urandom_range(0, 7) != 0));
      end
      bus.valid  = 1'b0;
      bus.active = 1'b1;
      wait_drain();
      check("drain lane0 queue", exp_q0.size(), 0);
      check("drain lane1 queue", exp_q1.size(), 0);
      check("drain recirc queue", exp_rc.size(), 0);

      // Sweep: four lanes, 16-bit symbols; lane order 0,1,2,3,0.
      w4[0] = 32'hAAAABBBB; w4[1] = 32'h11112222; w4[2] = 32'h33334444;
      w4[3] = 32'h55556666; w4[4] = 32'h77778888;
      for (int l = 0; l < 4; l++) cnt4[l] = 0;
      for (int j = 0; j < 5; j++) begin
         exp4[j % 4][cnt4[j % 4]]     = w4[j][31:16];
         exp4[j % 4][cnt4[j % 4] + 1] = w4[j][15:0];
         cnt4[j % 4] += 2;
      end
      rec4 = 1'b1;
      acc0 = 0;
      for (int j = 0; j < 5; j++) begin
         bus4.data_input = w4[j];
         bus4.valid      = 1'b1;
         @(negedge clk_4f);
         check($sformatf("sweep ready w%0d", j), {63'd0, bus4.ready}, 64'd1);
         if (j == 0) acc0 = cyc + 1;
         @(posedge clk_4f);
         #1;
      end
      bus4.valid = 1'b0;
      repeat (14) @(posedge clk_4f);
      #1;
      rec4 = 1'b0;
      for (int l = 0; l < 4; l++) begin
         n = 0;
         seen_first = 1'b0;
         for (int e = 0; e < log_lane.size(); e++) begin
            if (log_lane[e] == l) begin
               if (n < cnt4[l]) begin
                  check($sformatf("sweep lane%0d sym%0d", l, n), {48'd0, log_sym[e]},
                        {48'd0, exp4[l][n]});
               end
               if (l == 0 && n < 2) begin
                  check($sformatf("sweep lane0 timing sym%0d", n), log_cyc[e], acc0 + 1 + n);
               end
               n++;
               seen_first = 1'b1;
            end
         end
         check($sformatf("sweep lane%0d count", l), n, cnt4[l]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
